// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile writeback path.
//   DATA_W   : regfile word width
//   SEL_W    : register select width
//   NUM_REGS : number of architectural registers (2**SEL_W)
//   req_id_e : writeback requester identifiers, also used as grant-vector bit indices
package regfile_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned NUM_REGS = 2 ** SEL_W;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // The requester that is not 'r'.
    function automatic req_id_e req_other(input req_id_e r);
        return (r == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way writeback arbiter: grant logic plus the round-robin pointer. No data path.
// Ports:
//   clk  : clock, state updates on the rising edge
//   rst  : synchronous active-high reset; forces gnt=0 and pointer=ALU
//   req  : request vector, indexed by req_id_e (bit 0 = ALU, bit 1 = MEM)
//   gnt  : one-hot-or-zero grant, combinational from req and the pointer
// Parameters:
//   RR_EN : 1 = round-robin on contention, 0 = ALU always wins (pointer unused)
module rr_arbiter2
    import regfile_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_e ptr_q;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req[REQ_ALU] && req[REQ_MEM]) begin
                if (RR_EN != 0) begin
                    gnt[ptr_q] = 1'b1;
                end else begin
                    gnt[REQ_ALU] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

    // Any grant hands priority to the other side, even an uncontended one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_ALU;
        end else if (gnt[REQ_ALU]) begin
            ptr_q <= req_other(REQ_ALU);
        end else if (gnt[REQ_MEM]) begin
            ptr_q <= req_other(REQ_MEM);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port owner. Arbitrates ALU and load writebacks onto the single regfile
// write port and tracks outstanding writes per register so issue can stall on RAW hazards.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   alu_valid/ready/sel/data : ALU writeback handshake
//   mem_valid/ready/sel/data : load writeback handshake
//   rsv_en, rsv_sel       : issue stage reserves a destination register
//   rf_wen, rf_sel_rd, rf_rd : registered regfile write port (one-cycle latency)
//   busy                  : busy[i]=1 while a write to register i is outstanding
// Parameters: DATA_W, SEL_W, RR_EN (1 = round-robin, 0 = ALU fixed priority)
// Build option: define WB_ARB_R0_DISCARD_EN to make r0 read-only zero (writes to r0
//   handshake but never reach the regfile; r0 can never be reserved).
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned SEL_W  = regfile_pkg::SEL_W,
    parameter int unsigned RR_EN  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [SEL_W-1:0]        alu_sel,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [SEL_W-1:0]        mem_sel,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    rsv_en,
    input  logic [SEL_W-1:0]        rsv_sel,
    output logic                    rf_wen,
    output logic [SEL_W-1:0]        rf_sel_rd,
    output logic [DATA_W-1:0]       rf_rd,
    output logic [(2**SEL_W)-1:0]   busy
);
    import regfile_pkg::*;

    localparam int unsigned NumRegs = 2 ** SEL_W;

    logic [1:0]         gnt;
    logic               hs;
    logic               commit;
    logic [SEL_W-1:0]   win_sel;
    logic [DATA_W-1:0]  win_data;

    logic               rf_wen_d, rf_wen_q;
    logic [SEL_W-1:0]   rf_sel_d, rf_sel_q;
    logic [DATA_W-1:0]  rf_rd_d, rf_rd_q;
    logic [NumRegs-1:0] busy_d, busy_q;

    rr_arbiter2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req ({mem_valid, alu_valid}),
        .gnt (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign mem_ready = gnt[REQ_MEM];
    assign hs        = |gnt;
    assign win_sel   = gnt[REQ_MEM] ? mem_sel  : alu_sel;
    assign win_data  = gnt[REQ_MEM] ? mem_data : alu_data;

`ifdef WB_ARB_R0_DISCARD_EN
    // r0 writes complete the handshake but are swallowed here.
    assign commit = hs && (win_sel != '0);
`else
    assign commit = hs;
`endif

    always_comb begin
        rf_wen_d = commit;
        rf_sel_d = rf_sel_q;
        rf_rd_d  = rf_rd_q;
        if (commit) begin
            rf_sel_d = win_sel;
            rf_rd_d  = win_data;
        end
    end

    // Clear on the regfile commit edge, then set, so a same-edge reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q) begin
            busy_d[rf_sel_q] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_sel] = 1'b1;
        end
`ifdef WB_ARB_R0_DISCARD_EN
        busy_d[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q <= 1'b0;
            rf_sel_q <= '0;
            rf_rd_q  <= '0;
            busy_q   <= '0;
        end else begin
            rf_wen_q <= rf_wen_d;
            rf_sel_q <= rf_sel_d;
            rf_rd_q  <= rf_rd_d;
            busy_q   <= busy_d;
        end
    end

    assign rf_wen    = rf_wen_q;
    assign rf_sel_rd = rf_sel_q;
    assign rf_rd     = rf_rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a round-robin instance and a fixed-priority instance
// share one set of directed inputs; a cycle-level model checks both every cycle, and
// hand-computed literals pin the model on the key scenarios.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        alu_valid, mem_valid, rsv_en;
    logic [3:0]  alu_sel, mem_sel, rsv_sel;
    logic [15:0] alu_data, mem_data;

    logic [1:0]  alu_ready_w, mem_ready_w, wen_w;
    logic [3:0]  sel_w  [2];
    logic [15:0] rd_w   [2];
    logic [15:0] busy_w [2];

    regfile_wb_arbiter #(.DATA_W(16), .SEL_W(4), .RR_EN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready_w[0]), .alu_sel(alu_sel), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready_w[0]), .mem_sel(mem_sel), .mem_data(mem_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .rf_wen(wen_w[0]), .rf_sel_rd(sel_w[0]), .rf_rd(rd_w[0]), .busy(busy_w[0])
    );

    regfile_wb_arbiter #(.DATA_W(16), .SEL_W(4), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready_w[1]), .alu_sel(alu_sel), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready_w[1]), .mem_sel(mem_sel), .mem_data(mem_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel),
        .rf_wen(wen_w[1]), .rf_sel_rd(sel_w[1]), .rf_rd(rd_w[1]), .busy(busy_w[1])
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- model: index 0 = round-robin, 1 = fixed priority ----------------
    logic        m_wen      [2];
    logic [3:0]  m_sel      [2];
    logic [15:0] m_rd       [2];
    logic [15:0] m_busy     [2];
    logic        m_last_mem [2];  // most recent grant went to MEM
    bit          model_ok = 1'b0;

    // Grant as {mem, alu}. Contention: RR goes to whoever did not win last; FP goes to ALU.
    function automatic logic [1:0] exp_grant(input int k);
        if (rst) return 2'b00;
        if (alu_valid && mem_valid) begin
            if (k == 1) return 2'b01;
            return m_last_mem[k] ? 2'b01 : 2'b10;
        end
        return {mem_valid, alu_valid};
    endfunction

    task automatic model_step();
        logic [1:0]  g;
        logic [15:0] nb;
        logic [3:0]  ws;
        logic [15:0] wd;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_wen[k] = 1'b0; m_sel[k] = 4'h0; m_rd[k] = 16'h0;
                m_busy[k] = 16'h0; m_last_mem[k] = 1'b1;
            end else begin
                g  = exp_grant(k);
                nb = m_busy[k];
                if (m_wen[k]) nb[m_sel[k]] = 1'b0;
                if (rsv_en) nb[rsv_sel] = 1'b1;
`ifdef WB_ARB_R0_DISCARD_EN
                nb[0] = 1'b0;
`endif
                m_wen[k] = 1'b0;
                if (g != 2'b00) begin
                    ws = g[1] ? mem_sel : alu_sel;
                    wd = g[1] ? mem_data : alu_data;
                    m_last_mem[k] = g[1];
`ifdef WB_ARB_R0_DISCARD_EN
                    if (ws != 4'h0) begin
                        m_wen[k] = 1'b1; m_sel[k] = ws; m_rd[k] = wd;
                    end
`else
                    m_wen[k] = 1'b1; m_sel[k] = ws; m_rd[k] = wd;
`endif
                end
                m_busy[k] = nb;
            end
        end
        if (rst) model_ok = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle compare on the falling edge, inputs settled.
    initial forever begin
        @(negedge clk);
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0] g;
                g = exp_grant(k);
                chk($sformatf("alu_ready[%0d]", k), 32'(alu_ready_w[k]), 32'(g[0]));
                chk($sformatf("mem_ready[%0d]", k), 32'(mem_ready_w[k]), 32'(g[1]));
                chk($sformatf("rf_wen[%0d]", k), 32'(wen_w[k]), 32'(m_wen[k]));
                chk($sformatf("rf_sel_rd[%0d]", k), 32'(sel_w[k]), 32'(m_sel[k]));
                chk($sformatf("rf_rd[%0d]", k), 32'(rd_w[k]), 32'(m_rd[k]));
                chk($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(m_busy[k]));
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic drive(input logic av, input logic [3:0] as, input logic [15:0] ad,
                         input logic mv, input logic [3:0] ms, input logic [15:0] md,
                         input logic re, input logic [3:0] rs);
        alu_valid = av; alu_sel = as; alu_data = ad;
        mem_valid = mv; mem_sel = ms; mem_data = md;
        rsv_en = re; rsv_sel = rs;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] t3_ad    [4] = '{16'hA000, 16'hA001, 16'hA001, 16'hA002};
    logic [15:0] t3_md    [4] = '{16'hB000, 16'hB000, 16'hB001, 16'hB001};
    logic [15:0] t3_rr_rd [4] = '{16'hA000, 16'hB000, 16'hA001, 16'hB001};
    logic [3:0]  t3_rr_sl [4] = '{4'h1, 4'h2, 4'h1, 4'h2};
    logic [15:0] t3_fp_rd [4] = '{16'hA000, 16'hA001, 16'hA001, 16'hA002};

    initial begin
        rst = 1'b1;
        drive(1'b1, 4'h3, 16'h1234, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
        tick();
        tick();
        // Reset holds ready low even with a request pending.
        chk("t1_alu_ready", 32'(alu_ready_w[0]), 32'h0);
        chk("t1_rf_wen", 32'(wen_w[0]), 32'h0);
        chk("t1_busy", 32'(busy_w[0]), 32'h0);

        // Both valid from reset: RR alternates starting with ALU, FP always ALU.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h1, t3_ad[i], 1'b1, 4'h2, t3_md[i], 1'b0, 4'h0);
            chk($sformatf("t3_rr_alu_ready_%0d", i), 32'(alu_ready_w[0]), 32'((i % 2) == 0));
            chk($sformatf("t3_fp_alu_ready_%0d", i), 32'(alu_ready_w[1]), 32'h1);
            tick();
            chk($sformatf("t3_rr_wen_%0d", i), 32'(wen_w[0]), 32'h1);
            chk($sformatf("t3_rr_rd_%0d", i), 32'(rd_w[0]), 32'(t3_rr_rd[i]));
            chk($sformatf("t3_rr_sel_%0d", i), 32'(sel_w[0]), 32'(t3_rr_sl[i]));
            chk($sformatf("t3_fp_rd_%0d", i), 32'(rd_w[1]), 32'(t3_fp_rd[i]));
        end
        idle();
        tick();
        chk("t3_wen_drop", 32'(wen_w[0]), 32'h0);
        chk("t3_rd_hold", 32'(rd_w[0]), 32'hB001);

        // Single ALU request, one-cycle latency, then hold.
        drive(1'b1, 4'h3, 16'hBEEF, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
        chk("t2_alu_ready", 32'(alu_ready_w[0]), 32'h1);
        tick();
        idle();
        chk("t2_wen", 32'(wen_w[0]), 32'h1);
        chk("t2_sel", 32'(sel_w[0]), 32'h3);
        chk("t2_rd", 32'(rd_w[0]), 32'hBEEF);
        tick();
        chk("t2_wen_off", 32'(wen_w[0]), 32'h0);
        chk("t2_sel_hold", 32'(sel_w[0]), 32'h3);

        // Scoreboard: reserve r5, write it, busy falls the cycle after rf_wen.
        drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h5);
        tick();
        chk("t4_busy_set", 32'(busy_w[0]), 32'h0020);
        drive(1'b1, 4'h5, 16'h5555, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
        tick();
        idle();
        chk("t4_wen", 32'(wen_w[0]), 32'h1);
        chk("t4_busy_during_wen", 32'(busy_w[0]), 32'h0020);
        tick();
        chk("t4_busy_clr", 32'(busy_w[0]), 32'h0000);
        // Re-reserve on the commit edge: set wins.
        drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h5);
        tick();
        drive(1'b1, 4'h5, 16'h5A5A, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'h5);
        chk("t4_wen2", 32'(wen_w[0]), 32'h1);
        tick();
        idle();
        chk("t4_busy_set_wins", 32'(busy_w[0]), 32'h0020);
        tick();
        chk("t4_busy_stays", 32'(busy_w[0]), 32'h0020);

        // Move the RR pointer back to ALU, then both target r7.
        drive(1'b0, 4'h0, 16'h0, 1'b1, 4'h8, 16'h0000, 1'b0, 4'h0);
        tick();
        drive(1'b1, 4'h7, 16'h0001, 1'b1, 4'h7, 16'h0002, 1'b0, 4'h0);
        chk("t5_alu_first", 32'(alu_ready_w[0]), 32'h1);
        tick();
        chk("t5_rd0", 32'(rd_w[0]), 32'h0001);
        chk("t5_sel0", 32'(sel_w[0]), 32'h7);
        drive(1'b0, 4'h0, 16'h0, 1'b1, 4'h7, 16'h0002, 1'b0, 4'h0);
        chk("t5_mem_ready", 32'(mem_ready_w[0]), 32'h1);
        tick();
        idle();
        chk("t5_rd1", 32'(rd_w[0]), 32'h0002);
        chk("t5_fp_rd1", 32'(rd_w[1]), 32'h0002);
        tick();

        // r0 write and reservation.
        drive(1'b0, 4'h0, 16'h0, 1'b1, 4'h0, 16'hFFFF, 1'b1, 4'h0);
        chk("t6_mem_ready", 32'(mem_ready_w[0]), 32'h1);
        tick();
        idle();
`ifdef WB_ARB_R0_DISCARD_EN
        chk("t6_wen_r0", 32'(wen_w[0]), 32'h0);
        chk("t6_busy0", 32'(busy_w[0][0]), 32'h0);
`else
        chk("t6_wen_r0", 32'(wen_w[0]), 32'h1);
        chk("t6_rd_r0", 32'(rd_w[0]), 32'hFFFF);
        chk("t6_busy0", 32'(busy_w[0][0]), 32'h1);
`endif
        tick();

        // Reset mid-operation drops the in-flight write and all reservations.
        drive(1'b1, 4'h9, 16'h1234, 1'b0, 4'h0, 16'h0, 1'b1, 4'h2);
        tick();
        chk("t7_wen_before", 32'(wen_w[0]), 32'h1);
        rst = 1'b1;
        drive(1'b1, 4'hA, 16'h4321, 1'b1, 4'hB, 16'h0, 1'b0, 4'h0);
        chk("t7_alu_ready_rst", 32'(alu_ready_w[0]), 32'h0);
        chk("t7_mem_ready_rst", 32'(mem_ready_w[1]), 32'h0);
        tick();
        chk("t7_wen", 32'(wen_w[0]), 32'h0);
        chk("t7_sel", 32'(sel_w[0]), 32'h0);
        chk("t7_rd", 32'(rd_w[0]), 32'h0);
        chk("t7_busy", 32'(busy_w[0]), 32'h0);
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
